// File: rtl/cla_mp_seq_if.sv
// Handshake and data bundle for the multi-precision add/subtract sequencer.
// The request side carries the operand pair and op_sub. The response side
// carries result, carry and overflow. busy is exported alongside them.
interface cla_mp_seq_if #(
   parameter int WORDS = 4
);
   localparam int W = 10 * WORDS;

   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] opa;
   logic [W-1:0] opb;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         busy;

   // Producer/consumer side (drives requests, accepts results)
   modport master (
      output in_valid, op_sub, opa, opb, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow, busy
   );

   // Sequencer side
   modport slave (
      input  in_valid, op_sub, opa, opb, out_ready,
      output in_ready, out_valid, result, carry_out, overflow, busy
   );
endinterface

// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract sequencer. A single 10-bit carry-lookahead
// slice is reused once per word, least-significant word first. Each word's
// carry-out is chained into the next word's carry-in. Subtraction is
// A + ~B + 1: B is inverted when it is latched, and op_sub seeds word 0's
// carry-in.
module cla_mp_seq #(
   parameter int WORDS = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   cla_mp_seq_if.slave  bus
);
   localparam int W  = 10 * WORDS;
   localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [KW-1:0] k;
   logic          carry_reg;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic          sub_reg;
   logic [W-1:0]  res_reg;
   logic          cout_reg;
   logic          ovf_reg;
   logic          in_ready_reg;
   logic          out_valid_reg;
   logic          busy_reg;

   logic [9:0]    slice_a;
   logic [9:0]    slice_b;
   logic          slice_cin;
   logic [9:0]    slice_sum;
   logic          slice_cout;

   // 10-bit carry-lookahead adder. Each carry is built as a flat
   // sum-of-products of generate/propagate terms rather than a ripple chain.
   // The result is {cout, sum}.
   function automatic logic [10:0] cla10(input logic [9:0] a,
                                         input logic [9:0] b,
                                         input logic       cin);
      logic [9:0]  g;
      logic [9:0]  p;
      logic [10:0] c;
      logic        term;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int i = 0; i < 10; i++) begin
         // carry into bit i+1: any g[j] propagated through p[j+1..i], or cin through p[0..i]
         term = cin;
         for (int m = 0; m <= i; m++) term = term & p[m];
         c[i+1] = term;
         for (int j = 0; j <= i; j++) begin
            term = g[j];
            for (int m = j + 1; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
         end
      end
      return {c[10], p ^ c[9:0]};
   endfunction

   // Select word k of both latched operands and feed the shared slice
   always_comb begin
      slice_a   = a_reg[10*int'(k) +: 10];
      slice_b   = b_reg[10*int'(k) +: 10];
      slice_cin = (k == '0) ? sub_reg : carry_reg;
      {slice_cout, slice_sum} = cla10(slice_a, slice_b, slice_cin);
   end

   // Capture operands on accept; B is pre-inverted for subtraction
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.in_valid) begin
         a_reg   <= bus.opa;
         b_reg   <= bus.opb ^ {W{bus.op_sub}};
         sub_reg <= bus.op_sub;
      end
   end

   // Control FSM: accept, walk the words, then hold the result until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         k             <= '0;
         carry_reg     <= 1'b0;
         res_reg       <= '0;
         cout_reg      <= 1'b0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && in_ready_reg) begin
                  k            <= '0;
                  state        <= RUN;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
               end
            end
            RUN: begin
               res_reg[10*int'(k) +: 10] <= slice_sum;
               carry_reg <= slice_cout;
               k         <= k + KW'(1);
               if (k == K_LAST) begin
                  // slice_a/slice_b are the top word here, so bit 9 is the sign bit
                  cout_reg      <= slice_cout;
                  ovf_reg       <= slice_a[9] ^ slice_b[9] ^ slice_sum[9] ^ slice_cout;
                  state         <= DONE;
                  out_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state         <= IDLE;
                  out_valid_reg <= 1'b0;
                  busy_reg      <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state         <= IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.busy      = busy_reg;
   assign bus.result    = res_reg;
   assign bus.carry_out = cout_reg;
   assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_cla_mp_seq.sv
// Directed bench for cla_mp_seq with WORDS=4 (40-bit operands).
module tb_cla_mp_seq;
   localparam int WORDS = 4;
   localparam int W     = 10 * WORDS;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   logic [W-1:0] held;

   cla_mp_seq_if #(.WORDS(WORDS)) bus ();

   cla_mp_seq #(.WORDS(WORDS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one operation, measure latency, check outputs, then release it
   task automatic run_op(input string tag, input logic sub,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input logic exp_c,
                         input logic exp_v);
      int n;
      check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.op_sub   = sub;
      bus.opa      = a;
      bus.opb      = b;
      cyc();
      bus.in_valid = 1'b0;
      bus.opa      = '1;
      bus.opb      = '1;
      check({tag, " busy"}, 64'(bus.busy), 64'd1);
      n = 0;
      while (n < 20) begin
         cyc();
         n++;
         if (bus.out_valid) break;
      end
      check({tag, " latency"}, 64'(n), 64'd4);
      check({tag, " result"}, 64'(bus.result), 64'(exp_res));
      check({tag, " carry"}, 64'(bus.carry_out), 64'(exp_c));
      check({tag, " overflow"}, 64'(bus.overflow), 64'(exp_v));
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      check({tag, " ready after"}, 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      n_cmp         = 0;
      n_bad         = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op_sub    = 1'b0;
      bus.opa       = '0;
      bus.opb       = '0;
      bus.out_ready = 1'b0;
      cyc();
      cyc();
      check("rst in_ready", 64'(bus.in_ready), 64'd1);
      check("rst out_valid", 64'(bus.out_valid), 64'd0);
      check("rst busy", 64'(bus.busy), 64'd0);
      check("rst result", 64'(bus.result), 64'd0);
      check("rst carry", 64'(bus.carry_out), 64'd0);
      check("rst overflow", 64'(bus.overflow), 64'd0);
      #2 rst_n = 1'b1;
      cyc();

      run_op("wordcarry", 1'b0, 40'h00000003FF, 40'h0000000001, 40'h0000000400, 1'b0, 1'b0);
      run_op("ripple",    1'b0, 40'hFFFFFFFFFF, 40'h0000000001, 40'h0000000000, 1'b1, 1'b0);
      run_op("sub5m7",    1'b1, 40'h0000000005, 40'h0000000007, 40'hFFFFFFFFFE, 1'b0, 1'b0);
      run_op("sub7m5",    1'b1, 40'h0000000007, 40'h0000000005, 40'h0000000002, 1'b1, 1'b0);
      run_op("ovf add",   1'b0, 40'h7FFFFFFFFF, 40'h0000000001, 40'h8000000000, 1'b0, 1'b1);
      run_op("ovf sub",   1'b1, 40'h8000000000, 40'h0000000001, 40'h7FFFFFFFFF, 1'b1, 1'b1);

      // Backpressure: result held while out_ready stays low and inputs wiggle
      bus.in_valid = 1'b1;
      bus.op_sub   = 1'b0;
      bus.opa      = 40'h0000012345;
      bus.opb      = 40'h0000011111;
      cyc();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      check("bp valid", 64'(bus.out_valid), 64'd1);
      check("bp result", 64'(bus.result), 64'h23456);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = ~bus.in_valid;
         bus.opa      = 40'(i * 40'h1111111111);
         bus.op_sub   = bus.in_valid;
         cyc();
         check("bp hold result", 64'(bus.result), 64'h23456);
         check("bp hold carry", 64'(bus.carry_out), 64'd0);
         check("bp hold ovf", 64'(bus.overflow), 64'd0);
         check("bp in_ready", 64'(bus.in_ready), 64'd0);
         check("bp out_valid", 64'(bus.out_valid), 64'd1);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      cyc();
      bus.out_ready = 1'b0;
      check("bp release ready", 64'(bus.in_ready), 64'd1);
      check("bp release busy", 64'(bus.busy), 64'd0);
      run_op("after bp", 1'b1, 40'h0000000100, 40'h0000000001, 40'h00000000FF, 1'b1, 1'b0);

      // Reset during RUN discards the operation immediately
      bus.in_valid = 1'b1;
      bus.op_sub   = 1'b0;
      bus.opa      = 40'hFFFFFFFFFF;
      bus.opb      = 40'hFFFFFFFFFF;
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      cyc();
      held  = bus.result;
      rst_n = 1'b0;
      #1;
      check("mid rst out_valid", 64'(bus.out_valid), 64'd0);
      check("mid rst busy", 64'(bus.busy), 64'd0);
      check("mid rst in_ready", 64'(bus.in_ready), 64'd1);
      check("mid rst result", 64'(bus.result), 64'd0);
      cyc();
      #2 rst_n = 1'b1;
      cyc();
      run_op("post rst", 1'b0, 40'h0000000123, 40'h0000000456, 40'h0000000579, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
